// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle LEGv8 control sequencer
//
// Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK
// using the decoder's control fields, and handshakes with one shared
// instruction/data memory port. Issues one PC, register-file and
// status-register write pulse per instruction. Counts retired instructions
// and faults if the memory port stalls for too long.
//
// Parameters:
//   MEM_TIMEOUT  stall cycles tolerated on mem_ready before FAULT (0 = never)
//   CNT_W        width of instr_count
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   start                run request, honoured in IDLE/HALTED only
//   halt_req             stop after the current instruction (sampled at retire)
//   mem_ready            memory completion for if_req/dmem_read/dmem_write
//   dec_*                decoded control fields, stable from DECODE to retire
//   branch_taken         branch resolution, valid in EXECUTE
//   if_req, ir_load      instruction fetch request / IR latch
//   alu_en, sreg_write   ALU capture / status register write pulse
//   dmem_read/write      data memory requests
//   wb_sel               writeback source (0 ALU, 1 memory)
//   rf_write             register-file write pulse
//   pc_write, pc_src     PC update pulse / source (0 PC+4, 1 branch target)
//   busy, fault, state   status
//   instr_count          retired-instruction count (wraps)
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             mem_ready,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_reg_write,
  input  logic             dec_update_sreg,
  input  logic [2:0]       dec_branch_op,
  input  logic             branch_taken,
  output logic             if_req,
  output logic             ir_load,
  output logic             alu_en,
  output logic             sreg_write,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             wb_sel,
  output logic             rf_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_HALTED    = 3'd6;
  localparam logic [2:0] S_FAULT     = 3'd7;

  // Wide enough to hold MEM_TIMEOUT itself; with the timeout disabled the
  // counter is free to wrap since nothing compares against it.
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  count_q;
  logic              fault_q;
  logic              retire;
  logic              timeout_hit;
  logic              is_branch;
  logic              mem_conflict;

  assign is_branch    = (dec_branch_op != 3'd0);
  assign mem_conflict = dec_mem_read & dec_mem_write;
  // mem_ready on the limit cycle still completes the access.
  assign timeout_hit  = (MEM_TIMEOUT != 0) && !mem_ready &&
                        (wait_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    if_req     = 1'b0;
    ir_load    = 1'b0;
    alu_en     = 1'b0;
    sreg_write = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    wb_sel     = 1'b0;
    rf_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        // A load+store decode is illegal: fault without touching the datapath.
        if (mem_conflict) begin
          state_d = S_FAULT;
        end else begin
          alu_en     = 1'b1;
          sreg_write = dec_update_sreg;
          if (is_branch) begin
            retire = 1'b1;
            pc_src = branch_taken;
          end else if (dec_mem_read || dec_mem_write) begin
            state_d = S_MEMORY;
          end else if (dec_reg_write) begin
            state_d = S_WRITEBACK;
          end else begin
            retire = 1'b1;
          end
        end
      end
      S_MEMORY: begin
        dmem_read  = dec_mem_read;
        dmem_write = dec_mem_write;
        if (mem_ready) begin
          if (dec_mem_read) state_d = S_WRITEBACK;
          else              retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        rf_write = 1'b1;
        wb_sel   = dec_mem_read;
        retire   = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase

    if (retire) begin
      pc_write = 1'b1;
      state_d  = halt_req ? S_HALTED : S_FETCH;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      count_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_q <= '0;
      else if ((state_q == S_FETCH || state_q == S_MEMORY) && !mem_ready)
        wait_q <= wait_q + WAIT_W'(1);
      if (retire)
        count_q <= count_q + CNT_W'(1);
      if (state_d == S_FAULT)
        fault_q <= 1'b1;
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
  assign fault       = fault_q;
  assign busy        = (state_q >= S_FETCH) && (state_q <= S_WRITEBACK);

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the LEGv8 core. It sequences fetch, decode, execute, memory and writeback using the per-instruction control fields from the decoder, and handshakes with a shared instruction/data memory port. Compared with a single-cycle datapath, the register file, PC and status register each get one write-enable pulse per instruction. The block also drives the retired-instruction counter and detects memory timeouts.

Parameters:
MEM_TIMEOUT, 15, number of consecutive wait cycles allowed on mem_ready before FAULT; 0 disables the timeout
CNT_W, 32, width of instr_count

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  run request; honoured only in IDLE or HALTED
halt_req  in  1  stop after the current instruction; sampled only at retire
mem_ready  in  1  memory completion for the current if_req/dmem_read/dmem_write
dec_mem_read  in  1  decoded load
dec_mem_write  in  1  decoded store
dec_reg_write  in  1  decoded register-file write
dec_update_sreg  in  1  decoded flag-setting instruction
dec_branch_op  in  3  000 none, 001 B, 010 B.cond, 011 CBZ, 100 CBNZ
branch_taken  in  1  branch resolution from the datapath, valid in EXECUTE
if_req  out  1  instruction fetch request
ir_load  out  1  latch the instruction register
alu_en  out  1  ALU operand/result capture
sreg_write  out  1  status register write pulse
dmem_read  out  1  data read request
dmem_write  out  1  data write request
wb_sel  out  1  0 = ALU result, 1 = memory data
rf_write  out  1  register-file write pulse
pc_write  out  1  PC update pulse
pc_src  out  1  0 = PC+4, 1 = branch target
busy  out  1  high in FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK
fault  out  1  sticky error flag
state  out  3  encoded current state
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALTED=6, FAULT=7.
- Reset (asynchronous, reset_n low): state=IDLE, instr_count=0, wait counter=0, fault=0. All strobes are 0 while reset is asserted.
- Reset asserted mid-instruction aborts the instruction; no partial pulses follow deassertion.
- Output decoding:
  - Strobes are decoded from state and inputs; they are not registered.
  - State, wait counter, instr_count and fault are registered.
- IDLE: start=1 -> FETCH.
- FETCH:
  - if_req=1 for every cycle in FETCH.
  - When mem_ready=1: ir_load=1 in that same cycle, then -> DECODE.
- DECODE: one cycle, no strobes, -> EXECUTE. The dec_* inputs must be stable from DECODE until retire.
- EXECUTE: alu_en=1; sreg_write=dec_update_sreg.
  - dec_mem_read=1 and dec_mem_write=1 together -> FAULT, no other strobes.
  - dec_branch_op != 000 -> retire here with pc_src=branch_taken.
  - Else mem_read or mem_write -> MEMORY.
  - Else dec_reg_write=1 -> WRITEBACK.
  - Else retire (NOP/unknown opcode).
- MEMORY: dmem_read=dec_mem_read and dmem_write=dec_mem_write, held until mem_ready.
  - On mem_ready: a load -> WRITEBACK with wb_sel=1; a store retires.
- WRITEBACK: rf_write=1 for one cycle; wb_sel=dec_mem_read; then retire.
- Retire cycle:
  - pc_write=1; pc_src=0 unless set by a branch in EXECUTE.
  - instr_count increments by 1 and wraps at 2^CNT_W to 0.
  - Next state is HALTED if halt_req=1, else FETCH.
- HALTED: start=1 -> FETCH; otherwise stay.
- FAULT: fault=1, all strobes 0. Stays until reset.
- Wait counter:
  - Increments each cycle in FETCH/MEMORY with mem_ready=0; clears on state change.
  - If MEM_TIMEOUT!=0 and the counter equals MEM_TIMEOUT with mem_ready=0 -> FAULT.
  - If mem_ready=1 on the same cycle, mem_ready wins.
- Zero-wait latencies (start of FETCH to retire inclusive):
  - R/I-type ALU: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - NOP: 3 cycles
- start outside IDLE/HALTED is ignored. halt_req outside the retire cycle is ignored.
- mem_ready outside FETCH/MEMORY is ignored.

Test Plan:
- Reset, start=1, ADD decode (reg_write=1), mem_ready tied 1 -> state 1,2,3,5; rf_write in cycle 4 with wb_sel=0; pc_write=1, pc_src=0; instr_count=1.
- LDUR (mem_read=1, reg_write=1) with 3 stall cycles in MEMORY -> dmem_read high 4 cycles; WRITEBACK rf_write with wb_sel=1; 8 cycles total.
- CBZ (branch_op=011) with branch_taken=1, then CBNZ with branch_taken=0 -> both retire from EXECUTE; pc_src=1 then 0; no rf_write; sreg_write equals dec_update_sreg.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT on the 5th cycle, fault=1; start ignored; only reset_n clears it.
- halt_req=1 during an ADD's EXECUTE then dropped -> ignored; halt_req=1 at retire -> HALTED with busy=0; start=1 -> FETCH.
- CNT_W=4 with 16 NOPs -> instr_count wraps to 0. reset_n low mid-MEMORY -> IDLE immediately and instr_count=0.
